// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants for the IEC 60958 frame encoder.
// Preamble patterns, subframe slot map and block sizing.
package spdif_pkg;

    // Preambles, MSB first, relative to the level entering the preamble
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [4:0] SLOT_AUD_LO = 5'd4;
    localparam logic [4:0] SLOT_V      = 5'd28;
    localparam logic [4:0] SLOT_U      = 5'd29;
    localparam logic [4:0] SLOT_C      = 5'd30;
    localparam logic [4:0] SLOT_P      = 5'd31;

    localparam int FRAMES_PER_BLOCK = 192;
    localparam int SUBFRAME_SLOTS   = 32;
    localparam int AUD_W            = 24;

    typedef enum logic {
        SUB_L = 1'b0,
        SUB_R = 1'b1
    } sub_e;

endpackage

// File: rtl/spdif_bmc.sv
// spdif_bmc: biphase-mark line coder, one UI per tick.
// Preamble UIs are pattern bits relative to the entry line level.
module spdif_bmc (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic pre_i,
    input  logic pre_first_i,
    input  logic pre_bit_i,
    input  logic data_i,
    input  logic half_i,
    output logic line_o
);
    logic line_q, line_d;
    logic base_q, base_d;

    // Next UI level: preamble pattern or the two halves of a BMC cell
    always_comb begin
        base_d = pre_first_i ? line_q : base_q;
        line_d = line_q;
        if (pre_i) begin
            line_d = pre_bit_i ^ base_d;
        end else if (!half_i) begin
            line_d = ~line_q;
        end else begin
            line_d = line_q ^ data_i;
        end
    end

    // Line level and preamble entry level advance on UI boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= 1'b0;
            base_q <= 1'b0;
        end else if (tick_i) begin
            line_q <= line_d;
            base_q <= base_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/spdif_frame_encoder.sv
// spdif_frame_encoder: buffers one stereo sample and emits
// IEC 60958 consumer frames as a biphase-mark line signal.
module spdif_frame_encoder
    import spdif_pkg::*;
#(
    parameter int unsigned UI_DIV = 4,
    parameter logic [31:0] CS_LO  = 32'h0200_0004
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [AUD_W-1:0] s_left,
    input  logic [AUD_W-1:0] s_right,
    output logic             spdif_out,
    output logic             block_start,
    output logic             underrun
);
    localparam int DW = (UI_DIV > 1) ? $clog2(UI_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(UI_DIV - 1);
    localparam logic [7:0] FRAME_MAX = 8'(FRAMES_PER_BLOCK - 1);
    localparam logic [4:0] SLOT_MAX  = 5'(SUBFRAME_SLOTS - 1);

    logic [DW-1:0]    div_q, div_d;
    logic [7:0]       frame_q, frame_d;
    logic [4:0]       slot_q, slot_d;
    logic             half_q, half_d;
    sub_e             sub_q, sub_d;

    logic             full_q;
    logic [AUD_W-1:0] hold_l_q, hold_r_q;
    logic [AUD_W-1:0] work_l_q, work_r_q;
    logic             v_q;
    logic             block_start_q, underrun_q;

    logic             tick, load, xfer;
    logic [AUD_W-1:0] aud;
    logic [31:0]      aud_ext;
    logic [4:0]       aud_idx;
    logic             c_bit, par, data_bit;
    logic [7:0]       pre_pat;
    logic             pre, pre_first, pre_bit;

    assign tick    = (div_q == '0);
    assign load    = tick && slot_q == '0 && !half_q && sub_q == SUB_L;
    assign xfer    = s_valid && !full_q;
    assign s_ready = !full_q;

    // Position counters: UI divider, half cell, slot, subframe, frame
    always_comb begin
        div_d   = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        half_d  = half_q;
        slot_d  = slot_q;
        sub_d   = sub_q;
        frame_d = frame_q;
        if (tick) begin
            half_d = ~half_q;
            if (half_q) begin
                slot_d = slot_q + 5'd1;
                if (slot_q == SLOT_MAX) begin
                    sub_d = sub_e'(~sub_q);
                    if (sub_q == SUB_R) begin
                        frame_d = (frame_q == FRAME_MAX) ?
                                  8'd0 : frame_q + 8'd1;
                    end
                end
            end
        end
    end

    // Subframe assembly: slot bit, channel status, parity, preamble
    always_comb begin
        aud      = (sub_q == SUB_R) ? work_r_q : work_l_q;
        aud_ext  = {8'd0, aud};
        aud_idx  = slot_q - SLOT_AUD_LO;
        c_bit    = (frame_q[7:5] == 3'd0) ? CS_LO[frame_q[4:0]] : 1'b0;
        par      = ^{aud, v_q, 1'b0, c_bit};
        data_bit = 1'b0;
        unique case (1'b1)
            slot_q < SLOT_V:  data_bit = aud_ext[aud_idx];
            slot_q == SLOT_V: data_bit = v_q;
            slot_q == SLOT_U: data_bit = 1'b0;
            slot_q == SLOT_C: data_bit = c_bit;
            slot_q == SLOT_P: data_bit = par;
            default:          data_bit = 1'b0;
        endcase
        pre_pat   = (sub_q == SUB_R) ? PRE_W :
                    (frame_q == 8'd0) ? PRE_B : PRE_M;
        pre_bit   = pre_pat[~{slot_q[1:0], half_q}];
        pre       = slot_q < SLOT_AUD_LO;
        pre_first = slot_q == '0 && !half_q;
    end

    // Counters, handshake, load point and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            half_q        <= 1'b0;
            slot_q        <= '0;
            sub_q         <= SUB_L;
            frame_q       <= '0;
            full_q        <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            work_l_q      <= '0;
            work_r_q      <= '0;
            v_q           <= 1'b1;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            half_q        <= half_d;
            slot_q        <= slot_d;
            sub_q         <= sub_d;
            frame_q       <= frame_d;
            block_start_q <= load && frame_q == 8'd0;
            underrun_q    <= load && !full_q;
            if (xfer) begin
                hold_l_q <= s_left;
                hold_r_q <= s_right;
            end
            if (load) begin
                // an empty load point may still accept for the next frame
                full_q <= xfer;
                if (full_q) begin
                    work_l_q <= hold_l_q;
                    work_r_q <= hold_r_q;
                    v_q      <= 1'b0;
                end else begin
                    work_l_q <= '0;
                    work_r_q <= '0;
                    v_q      <= 1'b1;
                end
            end else if (xfer) begin
                full_q <= 1'b1;
            end
        end
    end

    assign block_start = block_start_q;
    assign underrun    = underrun_q;

    spdif_bmc u_bmc (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_i     (tick),
        .pre_i      (pre),
        .pre_first_i(pre_first),
        .pre_bit_i  (pre_bit),
        .data_i     (data_bit),
        .half_i     (half_q),
        .line_o     (spdif_out)
    );

endmodule

// File: tb/tb_spdif_frame_encoder.sv
// tb_spdif_frame_encoder: scoreboard bench with a BMC frame decoder.
// Accepted samples queue up; each decoded frame is checked against them.
module tb_spdif_frame_encoder;
    localparam logic [31:0] CS    = 32'h0200_0004;
    localparam logic [7:0]  B_PAT = 8'hE8;
    localparam logic [7:0]  M_PAT = 8'hE2;
    localparam logic [7:0]  W_PAT = 8'hE4;
    localparam int FR  = 128;
    localparam int BLK = 192;

    typedef struct {
        int          e;
        logic [23:0] l;
        logic [23:0] r;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        s_ready, spdif_out, block_start, underrun;

    spdif_frame_encoder #(.UI_DIV(1), .CS_LO(CS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .spdif_out  (spdif_out),
        .block_start(block_start),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   un_cnt = 0;
    smp_t q[$];

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endfunction

    function automatic int cur_ui();
        return (cyc == 0) ? 0 : (cyc - 1) % FR;
    endfunction

    // Transfer capture: every accepted sample is an expected frame
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc <= 0;
            q.delete();
        end else begin
            if (s_valid && s_ready) begin
                q.push_back('{e: cyc, l: s_left, r: s_right});
                xfer_cnt <= xfer_cnt + 1;
            end
            cyc <= cyc + 1;
        end
    end

    logic [127:0] fbuf;
    logic [191:0] cs_acc;
    logic         prev_lvl = 1'b0;
    logic         have_exp = 1'b0;
    logic         blk_ok = 1'b0;
    logic         exp_v, exp_c;
    logic [23:0]  exp_l, exp_r;
    int           exp_fib;
    int           stray;
    int           last_bs = -1;

    task automatic check_frame();
        logic        base;
        logic [7:0]  pre;
        logic [31:0] bits;
        logic [23:0] ea;
        int          terr;
        int          o;
        for (int h = 0; h < 2; h++) begin
            o    = h * 64;
            base = (h == 1) ? fbuf[63] : prev_lvl;
            for (int i = 0; i < 8; i++) pre[7-i] = fbuf[o+i] ^ base;
            terr = 0;
            bits = '0;
            for (int s = 4; s < 32; s++) begin
                if (fbuf[o+2*s] == fbuf[o+2*s-1]) terr++;
                bits[s] = fbuf[o+2*s] ^ fbuf[o+2*s+1];
            end
            ea = (h == 1) ? exp_r : exp_l;
            if (h == 1) chk("pre_w", 64'(pre), 64'(W_PAT));
            else chk("pre_bm", 64'(pre),
                     64'((exp_fib == 0) ? B_PAT : M_PAT));
            chk("audio", 64'(bits[27:4]), 64'(ea));
            chk("v_bit", 64'(bits[28]), 64'(exp_v));
            chk("u_bit", 64'(bits[29]), 64'd0);
            chk("c_bit", 64'(bits[30]), 64'(exp_c));
            chk("parity", 64'(bits[31]),
                64'(^{ea, exp_v, exp_c}));
            chk("transitions", 64'(terr), 64'd0);
            if (h == 0) cs_acc[exp_fib] = bits[30];
        end
        chk("stray_pulse", 64'(stray), 64'd0);
        if (blk_ok && exp_fib == BLK - 1) begin
            chk("cs_lo", 64'(cs_acc[31:0]), 64'(CS));
            chk("cs_hi_zero", 64'(|cs_acc[191:32]), 64'd0);
            blk_ok = 1'b0;
        end
    endtask

    // Monitor: collect UIs, pop expectations at each frame start
    always @(negedge clk) begin
        int   ui;
        int   fib;
        smp_t s;
        if (!rst_n) begin
            prev_lvl = 1'b0;
            have_exp = 1'b0;
            blk_ok   = 1'b0;
            last_bs  = -1;
        end else if (cyc > 0) begin
            ui  = (cyc - 1) % FR;
            fib = ((cyc - 1) / FR) % BLK;
            if (underrun) un_cnt++;
            if (ui == 0) begin
                if (q.size() > 0 && q[0].e < cyc - 1) begin
                    s     = q.pop_front();
                    exp_v = 1'b0;
                    exp_l = s.l;
                    exp_r = s.r;
                end else begin
                    exp_v = 1'b1;
                    exp_l = '0;
                    exp_r = '0;
                end
                exp_c    = (fib < 32) ? CS[fib] : 1'b0;
                exp_fib  = fib;
                have_exp = 1'b1;
                stray    = 0;
                if (fib == 0) blk_ok = 1'b1;
                chk("block_start", 64'(block_start), 64'(fib == 0));
                chk("underrun", 64'(underrun), 64'(exp_v));
            end else if (block_start || underrun) begin
                stray++;
            end
            if (block_start) begin
                if (last_bs >= 0)
                    chk("bs_period", 64'(cyc - 1 - last_bs), 64'd24576);
                last_bs = cyc - 1;
            end
            fbuf[ui] = spdif_out;
            if (ui == FR - 1 && have_exp) begin
                check_frame();
                prev_lvl = fbuf[127];
            end
        end
    end

    int seen_x = 0;
    int hold_n = 0;
    bit en = 1'b1;
    int dly = 0;

    // mode 0: random, 1: valid held with counting data, 2: idle
    task automatic apply(int mode);
        if (xfer_cnt != seen_x) begin
            seen_x = xfer_cnt;
            if (mode == 1) begin
                hold_n++;
                s_left  = 24'(hold_n);
                s_right = 24'(hold_n) ^ 24'h80_0000;
            end else begin
                s_left  = 24'($urandom);
                s_right = 24'($urandom);
            end
        end
        if (mode == 0) begin
            if (cur_ui() == 0) begin
                en  = ($urandom % 5) != 0;
                dly = int'($urandom_range(0, 100));
            end
            s_valid = en && cur_ui() >= dly;
        end else begin
            s_valid = (mode == 1);
        end
    endtask

    task automatic drive(int n, int mode);
        repeat (n) begin
            apply(mode);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ui(int target, int mode);
        int n = 0;
        while (cur_ui() != target && n < 300) begin
            drive(1, mode);
            n++;
        end
        chk("wait_ui", 64'(cur_ui()), 64'(target));
    endtask

    initial begin
        int x0;
        int u0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_spdif", 64'(spdif_out), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);
        chk("rst_bs", 64'(block_start), 64'd0);
        chk("rst_under", 64'(underrun), 64'd0);

        rst_n   = 1'b1;
        s_left  = 24'h00_0001;
        s_right = 24'h80_0000;
        s_valid = 1'b1;
        @(negedge clk);
        #1;
        drive(195 * FR - 1, 0);

        drive(2 * FR, 1);
        wait_ui(0, 1);
        x0 = xfer_cnt;
        u0 = un_cnt;
        drive(4 * FR, 1);
        chk("bp_xfers", 64'(xfer_cnt - x0), 64'd4);
        chk("bp_underruns", 64'(un_cnt - u0), 64'd0);
        u0 = un_cnt;
        drive(FR, 2);
        drive(2 * FR, 1);
        chk("drop_underruns", 64'(un_cnt - u0), 64'd1);

        wait_ui(98, 1);
        chk("pre_rst_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("async_spdif", 64'(spdif_out), 64'd0);
        chk("async_ready", 64'(s_ready), 64'd1);
        chk("async_bs", 64'(block_start), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(3 * FR, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spdif_frame_encoder.md
# spdif_frame_encoder

Downstream stage of the I2S-to-S/PDIF path. It takes parallel stereo PCM samples from the I2S deserializer through a valid/ready handshake and builds IEC 60958 consumer frames: preamble, 24-bit audio, V/U/C/P bits and the 192-frame channel-status block. It then biphase-mark encodes the bitstream onto the optical transmitter pin. One stereo sample is buffered, so the upstream stage may run loosely coupled to the output frame rate.

## Interface
- `UI_DIV`, default 4: clk cycles per BMC unit interval (half bit cell); must be ≥1. At 24.576 MHz and 4, the output runs at 48 kHz.
- `CS_LO`, default 32'h0200_0004: channel-status bits 0–31 (bit 2 is copy permitted; bits 24–27 = 0010 for 48 kHz). Channel-status bits 32–191 are 0.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_valid` in 1: stereo sample present.
- `s_ready` out 1: holding register empty.
- `s_left` in 24: left sample, two's complement.
- `s_right` in 24: right sample, two's complement.
- `spdif_out` out 1: BMC line output.
- `block_start` out 1: one-cycle pulse on the first clk of frame 0's B preamble.
- `underrun` out 1: one-cycle pulse when a frame starts with an empty holding register.

## Operation
- **Reset values:** `spdif_out`=0, `s_ready`=1, `block_start`=0, `underrun`=0, frame count 0, slot 0, UI count 0, line level 0, holding register empty. Reset asserted mid-frame aborts the frame immediately. After release, output restarts at frame 0, B preamble.
- **Handshake:** transfer occurs on a clk edge with `s_valid & s_ready`. The sample is then held, and `s_ready` is 0 until it is loaded.
- **Load point:** the first clk of each frame (slot 0, UI 0 of the left subframe).
  - Holding register full: copy to the working register, mark it empty, and set V=0 for both subframes.
  - Holding register empty: the working audio is 0, V=1 for both subframes, and `underrun` pulses.
  - A transfer on the same edge as an empty load point fills the holding register for the next frame only.
- **Subframe (32 slots):**
  - 0–3: preamble.
  - 4–27: audio, LSB first.
  - 28: V.
  - 29: U=0.
  - 30: C = channel-status bit [frame count] (same for L and R).
  - 31: P, even parity over slots 4–30.
- **Preambles (8 UIs, MSB first):**
  - B = 11101000 on the left subframe of frame 0.
  - M = 11100010 on the left subframe of frames 1–191.
  - W = 11100100 on every right subframe.
  - Each UI is XORed with the line level of the final UI before it.
- **BMC for slots 4–31:**
  - First UI = inverse of the previous UI level (transition at every cell boundary).
  - Second UI = first UI XOR bit.
- **Frame count:** 0..191 and wraps to 0 after frame 191.
- **Arithmetic:** parity is an XOR reduction. Counters are sized exactly: frame 8 bits, slot 5 bits, half 1 bit, UI log2(UI_DIV).

## Timing
- One UI = UI_DIV clk cycles, subframe = 64 UIs, frame = 128·UI_DIV cycles.
- `spdif_out` is registered and changes only on UI boundaries.
- Latency: a sample accepted during frame n is transmitted in frame n+1. First UI of its left preamble: at the next load point.
- `s_ready` rises on the clk after the load point. At most one transfer per frame.
- `block_start` and `underrun` coincide with the load-point clk when both apply.
- The first frame after reset is always an underrun frame.

## Structure
- Package `spdif_pkg` holds:
  - preamble constants `PRE_B`, `PRE_M`, `PRE_W`;
  - slot indices `SLOT_AUD_LO`, `SLOT_V`, `SLOT_U`, `SLOT_C`, `SLOT_P`;
  - `FRAMES_PER_BLOCK`=192 and `SUBFRAME_SLOTS`=32.
- Sub-module `spdif_bmc`: takes a slot bit or preamble pattern plus a preamble flag, tracks the line level, and produces the UI output. The top level owns the handshake, counters, subframe assembly and parity.

## Test plan
The bench includes a BMC decoder; all scenarios use UI_DIV=1.
- **Reset:** `rst_n` low. Then `spdif_out`=0 and `s_ready`=1. After release, first frame UIs 0–7 = 11101000, `underrun` and `block_start` pulse on cycle 0, and both subframes decode V=1, audio 0.
- **Data path:** send L=24'h000001, R=24'h800000. The next frame decodes L audio 000001 with P=1, R audio 800000 with P=1, and V=0 on both.
- **Block sequencing:** stream for 194 frames. `block_start` pulses exactly every 24576 cycles. The decoder sees B only at frame 0, M elsewhere and W on every right subframe. The frame count wraps 191→0.
- **Channel status:** collect C over one block. Bits 0–31 equal 32'h0200_0004 (bit 2 and bit 25 set) and bits 32–191 are all 0.
- **Backpressure/underrun:** hold `s_valid`=1 with an incrementing sample. Exactly one transfer per 128 cycles, no underrun. Drop `s_valid` for one frame: exactly one `underrun` pulse, V=1 on that frame.
- **Reset mid-frame:** assert `rst_n` at slot 17 of a right subframe. `spdif_out` goes to 0 asynchronously. After release, restart with B at frame 0. Every data-cell boundary shows a transition.
